// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN classifier control path.
// Byte/state widths plus the ASCII mapping of the result digit.
package snn_pkg;

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        SEND
    } ctrl_state_t;

    localparam int         NUM_BYTES  = 98;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam int         BYTE_AW    = 7;
    localparam int         IDLE_W     = 17;

    // Results above 9 are passed through unchanged, giving 0x3A..0x3F.
    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_ZERO + {4'b0000, d};
    endfunction

endpackage

// File: rtl/snn_rx_timer.sv
// Image byte counter with an idle timeout that drops a partial image
// so the next received byte is treated as pixel byte 0 again.
module snn_rx_timer
    import snn_pkg::*;
#(
    parameter int NB  = 98,
    parameter int TMO = 104160
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_rdy,
    input  logic               load_en,
    input  logic               clr,
    output logic [BYTE_AW-1:0] byte_cnt,
    output logic               last_byte,
    output logic               timeout
);

    localparam logic [BYTE_AW-1:0] LAST_CNT = BYTE_AW'(NB - 1);
    localparam logic [BYTE_AW-1:0] CNT_ONE  = BYTE_AW'(1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(TMO - 1);
    localparam logic [IDLE_W-1:0]  IDLE_ONE = IDLE_W'(1);

    logic [BYTE_AW-1:0] r_cnt;
    logic [IDLE_W-1:0]  r_idle;
    logic               w_accept;
    logic               w_empty;

    assign w_accept  = load_en & rx_rdy;
    assign w_empty   = (r_cnt == '0);
    assign last_byte = (r_cnt == LAST_CNT);
    assign byte_cnt  = r_cnt;

    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout = load_en & ~rx_rdy & ~w_empty & (r_idle == IDLE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idle <= '0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_idle <= '0;
        end else begin
            if (rx_rdy || timeout || w_empty) begin
                r_idle <= '0;
            end else if (load_en) begin
                r_idle <= r_idle + IDLE_ONE;
            end
            if (w_accept) begin
                r_cnt <= last_byte ? '0 : r_cnt + CNT_ONE;
            end else if (timeout) begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/snn_ctrl.sv
// Sequencer: UART bytes -> input RAM, start the SNN core, wait for the
// classification and send the result digit back as one ASCII byte.
module snn_ctrl #(
    parameter int NUM_BYTES   = snn_pkg::NUM_BYTES,
    parameter int TIMEOUT_CYC = 104160
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_rdy,
    input  logic [7:0]                 rx_data,
    input  logic                       tx_rdy,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       ram_we,
    output logic [snn_pkg::BYTE_AW-1:0] ram_addr,
    output logic [7:0]                 ram_wdata,
    output logic                       core_start,
    input  logic                       core_done,
    input  logic [3:0]                 core_result,
    output logic [7:0]                 led
);

    import snn_pkg::*;

    ctrl_state_t        r_state;
    logic               r_ram_we;
    logic [BYTE_AW-1:0] r_ram_addr;
    logic [7:0]         r_ram_wdata;
    logic               r_core_start;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic [3:0]         r_result;
    logic               r_busy;

    logic [BYTE_AW-1:0] w_byte_cnt;
    logic               w_last_byte;
    logic               w_timeout;
    logic               w_load_en;
    logic               w_clr;

    assign w_load_en = (r_state == LOAD);
    assign w_clr     = ~w_load_en;

    snn_rx_timer #(
        .NB  (NUM_BYTES),
        .TMO (TIMEOUT_CYC)
    ) u_rx_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_rdy    (rx_rdy),
        .load_en   (w_load_en),
        .clr       (w_clr),
        .byte_cnt  (w_byte_cnt),
        .last_byte (w_last_byte),
        .timeout   (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= LOAD;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_core_start <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_result     <= '0;
        end else begin
            r_ram_we     <= 1'b0;
            r_core_start <= 1'b0;
            r_tx_start   <= 1'b0;
            unique case (r_state)
                LOAD: begin
                    if (rx_rdy) begin
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= w_byte_cnt;
                        r_ram_wdata <= rx_data;
                        if (w_last_byte) begin
                            r_state <= START;
                        end
                    end
                end
                // The last write lands while we sit here, before the core starts.
                START: begin
                    r_core_start <= 1'b1;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        r_result  <= core_result;
                        r_tx_data <= ascii_digit(core_result);
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (tx_rdy) begin
                        r_tx_start <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (r_state != LOAD);
        end
    end

    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_wdata  = r_ram_wdata;
    assign core_start = r_core_start;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign led        = {r_busy, 3'b000, r_result};

endmodule

// File: tb/tb_snn_ctrl.sv
// Directed-plus-random bench for snn_ctrl against a byte-level model
// of where each received pixel byte must land in the input RAM.
module tb_snn_ctrl;

    localparam int NB  = 98;
    localparam int TMO = 300;

    logic       clk;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       tx_rdy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       core_start;
    logic       core_done;
    logic [3:0] core_result;
    logic [7:0] led;

    snn_ctrl #(
        .NUM_BYTES   (NB),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .tx_rdy      (tx_rdy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int ncyc = 0;
    int last_rx = -1;
    int txr_rise = -1;
    bit prev_txr = 1'b0;
    int wa[$];
    int wd[$];
    int wcy[$];
    int cs_q[$];
    int txd_q[$];
    int txc_q[$];

    int ea[$];
    int ed[$];
    int m_pos = 0;

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (ram_we) begin
                wa.push_back(int'(ram_addr));
                wd.push_back(int'(ram_wdata));
                wcy.push_back(ncyc);
            end
            if (core_start) cs_q.push_back(ncyc);
            if (tx_start) begin
                txd_q.push_back(int'(tx_data));
                txc_q.push_back(ncyc);
            end
            if (rx_rdy) last_rx = ncyc;
            if (tx_rdy && !prev_txr) txr_rise = ncyc;
            prev_txr = tx_rdy;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        wa.delete(); wd.delete(); wcy.delete();
        cs_q.delete(); txd_q.delete(); txc_q.delete();
        ea.delete(); ed.delete();
    endtask

    task automatic send_byte(input logic [7:0] d);
        ea.push_back(m_pos);
        ed.push_back(int'(d));
        m_pos = (m_pos == NB - 1) ? 0 : m_pos + 1;
        rx_rdy  = 1'b1;
        rx_data = d;
        tick();
        rx_rdy  = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic send_bytes(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            send_byte(ramp ? 8'(i) : 8'($urandom));
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, wa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            chk({tag, "_addr"}, wa[i], ea[i]);
            chk({tag, "_data"}, wd[i], ed[i]);
        end
    endtask

    task automatic wait_cs(input int bound);
        int n = 0;
        while (cs_q.size() == 0 && n < bound) begin
            tick();
            n++;
        end
        chk("core_start_seen", int'(cs_q.size() != 0), 1);
    endtask

    task automatic wait_tx(input int bound);
        int n = 0;
        while (txd_q.size() == 0 && n < bound) begin
            tick();
            n++;
        end
        chk("tx_start_seen", int'(txd_q.size() != 0), 1);
    endtask

    task automatic do_done(input logic [3:0] r);
        core_result = r;
        core_done   = 1'b1;
        tick();
        core_done   = 1'b0;
        core_result = 4'd0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_tx_start"}, int'(tx_start), 0);
        chk({tag, "_tx_data"}, int'(tx_data), 0);
        chk({tag, "_ram_we"}, int'(ram_we), 0);
        chk({tag, "_ram_addr"}, int'(ram_addr), 0);
        chk({tag, "_ram_wdata"}, int'(ram_wdata), 0);
        chk({tag, "_core_start"}, int'(core_start), 0);
        chk({tag, "_led"}, int'(led), 0);
    endtask

    initial begin
        int res;
        rst_n = 1'b1;
        rx_rdy = 1'b0;
        rx_data = 8'd0;
        tx_rdy = 1'b1;
        core_done = 1'b0;
        core_result = 4'd0;
        #2;
        rst_n = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Full ramp image, result 7.
        clear_all();
        send_bytes(NB, 1'b1);
        wait_cs(20);
        repeat (5) tick();
        check_writes("ramp");
        chk("ramp_cs_count", cs_q.size(), 1);
        if (cs_q.size() != 0) chk("ramp_cs_timing", cs_q[0], last_rx + 2);
        if (wcy.size() != 0) chk("ramp_we_timing", wcy[wcy.size()-1], last_rx + 1);
        chk("ramp_busy", int'(led[7]), 1);
        do_done(4'd7);
        wait_tx(20);
        repeat (3) tick();
        chk("ramp_tx_count", txd_q.size(), 1);
        if (txd_q.size() != 0) chk("ramp_tx_data", txd_q[0], 8'h30 + 7);
        chk("ramp_led", int'(led), 8'h07);

        // Partial image discarded by timeout, then a full image.
        clear_all();
        send_bytes(50, 1'b0);
        repeat (TMO + 10) tick();
        m_pos = 0;
        send_bytes(NB, 1'b0);
        wait_cs(20);
        repeat (5) tick();
        check_writes("tmo");
        chk("tmo_cs_count", cs_q.size(), 1);
        do_done(4'd12);
        wait_tx(20);
        if (txd_q.size() != 0) chk("tmo_tx_data", txd_q[0], 8'h30 + 12);

        // Bytes arriving while the core runs are dropped.
        clear_all();
        send_bytes(NB, 1'b0);
        wait_cs(20);
        for (int i = 0; i < 3; i++) begin
            rx_rdy = 1'b1;
            rx_data = 8'($urandom);
            tick();
            rx_rdy = 1'b0;
            tick();
        end
        repeat (3) tick();
        check_writes("drop");
        res = $urandom_range(0, 9);
        do_done(4'(res));
        wait_tx(20);
        if (txd_q.size() != 0) chk("drop_tx_data", txd_q[0], 8'h30 + res);

        // Transmit held off by tx_rdy; next image starts at address 0.
        clear_all();
        tx_rdy = 1'b0;
        send_bytes(NB, 1'b0);
        wait_cs(20);
        repeat (2) tick();
        check_writes("bp");
        core_result = 4'd3;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_result = 4'd0;
        chk("bp_led_m1", int'(led), 8'h83);
        repeat (500) tick();
        chk("bp_tx_held", txd_q.size(), 0);
        tx_rdy = 1'b1;
        wait_tx(10);
        repeat (3) tick();
        chk("bp_tx_count", txd_q.size(), 1);
        if (txd_q.size() != 0) begin
            chk("bp_tx_data", txd_q[0], 8'h33);
            chk("bp_tx_timing", txc_q[0], txr_rise + 1);
        end
        chk("bp_led", int'(led), 8'h03);

        // Spurious core_done while loading.
        clear_all();
        do_done(4'd9);
        repeat (5) tick();
        chk("spur_led", int'(led), 8'h03);
        chk("spur_tx", txd_q.size(), 0);
        chk("spur_cs", cs_q.size(), 0);
        chk("spur_we", wa.size(), 0);

        // Reset in the middle of an image.
        clear_all();
        send_bytes(40, 1'b0);
        check_writes("pre_rst");
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        clear_all();
        m_pos = 0;
        send_bytes(1, 1'b0);
        repeat (2) tick();
        check_writes("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
